// File: rtl/sha256_miner_pkg.sv
// Shared definitions for the SHA-256 mining job controller.
//   - Field widths of the block header, digest and nonce.
//   - Sweeper FSM state encodings.
//   - Byte-swap helpers used for nonce insertion and hash ordering.
package sha256_miner_pkg;

  localparam int HEADER_W = 640;
  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CORE_RST = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_CHECK    = 3'd4;
  localparam logic [2:0] S_REPORT   = 3'd5;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [DIGEST_W-1:0] bswap256(input logic [DIGEST_W-1:0] x);
    logic [DIGEST_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGEST_W / 8; i++) begin
      r[8*i +: 8] = x[8*(DIGEST_W/8-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_target_cmp.sv
// Combinational difficulty check.
// The core emits its digest in SHA byte order; the hash compared against the
// target is the little-endian integer of those bytes, so the digest is
// byte-reversed before an unsigned <= compare.
//   i_digest : raw core digest
//   i_target : 256-bit target integer
//   o_hit    : 1 when byte-reversed digest <= target
module sha256_target_cmp
  import sha256_miner_pkg::*;
(
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic [DIGEST_W-1:0] i_target,
  output logic                o_hit
);

  logic [DIGEST_W-1:0] w_hash;

  assign w_hash = bswap256(i_digest);
  assign o_hit  = (w_hash <= i_target);

endmodule

// File: rtl/sha256_nonce_sweeper.sv
// Job-level controller for one double-SHA-256 core.
// Accepts a job (header, inclusive nonce range, target), runs the core once
// per nonce by pulsing its synchronous reset, and reports the first hit or
// range exhaustion on a valid/ready result port.
//   clk, reset_n                : clock, asynchronous active-low reset
//   job_*                       : job offer (valid/ready), sampled on accept
//   abort                       : cancel the running job, no result
//   core_reset/core_header      : drive the core; core_digest comes back
//   res_*                       : result (valid/ready), held until consumed
//   busy, cur_nonce             : status
module sha256_nonce_sweeper
  import sha256_miner_pkg::*;
#(
  parameter int CORE_LATENCY = 200,
  parameter int RESET_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [HEADER_W-1:0] job_header,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [NONCE_W-1:0]  job_nonce_end,
  input  logic [DIGEST_W-1:0] job_target,
  input  logic                abort,
  output logic                core_reset,
  output logic [HEADER_W-1:0] core_header,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_found,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [DIGEST_W-1:0] res_hash,
  output logic                busy,
  output logic [NONCE_W-1:0]  cur_nonce
);

  localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] RUN_LAST = 32'(CORE_LATENCY - 1);

  state_t                       r_state;
  logic [HEADER_W-1:NONCE_W]    r_header_hi;
  logic [NONCE_W-1:0]           r_nonce_end;
  logic [DIGEST_W-1:0]          r_target;
  logic [31:0]                  r_cnt;
  logic                         w_hit;
  logic                         w_last;
  logic                         w_unused_nonce_field;

  // The job's own nonce field is always overwritten by the swept nonce.
  assign w_unused_nonce_field = ^job_header[NONCE_W-1:0];

  assign job_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_last    = (cur_nonce == r_nonce_end);

  sha256_target_cmp u_cmp (
    .i_digest (core_digest),
    .i_target (r_target),
    .o_hit    (w_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_header_hi <= '0;
      r_nonce_end <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      core_reset  <= 1'b1;
      core_header <= '0;
      cur_nonce   <= '0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_nonce   <= '0;
      res_hash    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          core_reset <= 1'b1;
          if (job_valid) begin
            r_header_hi <= job_header[HEADER_W-1:NONCE_W];
            r_nonce_end <= job_nonce_end;
            r_target    <= job_target;
            cur_nonce   <= job_nonce_start;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Header nonce field is little-endian on the wire.
          core_header <= {r_header_hi, bswap32(cur_nonce)};
          r_cnt       <= '0;
          r_state     <= S_CORE_RST;
        end
        S_CORE_RST: begin
          if (r_cnt == RST_LAST) begin
            r_cnt      <= '0;
            core_reset <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RUN: begin
          if (r_cnt == RUN_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          // Core stays out of reset through CHECK so the digest is held.
          core_reset <= 1'b1;
          if (w_hit || w_last) begin
            res_valid <= 1'b1;
            res_found <= w_hit;
            res_nonce <= cur_nonce;
            res_hash  <= core_digest;
            r_state   <= S_REPORT;
          end else begin
            cur_nonce <= cur_nonce + 32'd1;
            r_state   <= S_LOAD;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          core_reset <= 1'b1;
          res_valid  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase

      // Abort overrides whatever the state logic chose, REPORT included.
      if (abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        core_reset <= 1'b1;
        res_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_nonce_sweeper.sv
// Bench for sha256_nonce_sweeper with a behavioural stand-in for the core.
// The stand-in returns a known digest for one chosen nonce, a near-miss
// digest for every other nonce, and all-zero (which would look like a hit)
// until CORE_LATENCY cycles after its reset drops.
module tb_sha256_nonce_sweeper;

  localparam int CL    = 200;
  localparam int RC    = 2;
  localparam int TRIAL = 1 + RC + CL + 1;

  localparam logic [255:0] GEN_INT  = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] MISS_INT = {64'h00000000_FFFF0001, 192'h0};
  localparam logic [255:0] TGT_GEN  = {64'h00000000_FFFF0000, 192'h0};
  localparam logic [639:0] HDR_A    = {20{32'h0123_4567}};
  localparam logic [639:0] HDR_B    = {20{32'h89AB_CDEF}};

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_header;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic [255:0] job_target;
  logic         abort;
  logic         core_reset;
  logic [639:0] core_header;
  logic [255:0] core_digest;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         busy;
  logic [31:0]  cur_nonce;

  always #5 clk = ~clk;

  sha256_nonce_sweeper #(.CORE_LATENCY(CL), .RESET_CYCLES(RC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .job_target      (job_target),
    .abort           (abort),
    .core_reset      (core_reset),
    .core_header     (core_header),
    .core_digest     (core_digest),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .res_nonce       (res_nonce),
    .res_hash        (res_hash),
    .busy            (busy),
    .cur_nonce       (cur_nonce)
  );

  function automatic logic [31:0] sw32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] rev256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- core stand-in ----------------
  int unsigned  core_cnt = 0;
  logic [31:0]  hit_nonce = 32'h0;
  initial forever begin
    @(posedge clk);
    if (core_reset) core_cnt = 0;
    else if (core_cnt < 100000) core_cnt = core_cnt + 1;
  end
  assign core_digest = (core_reset || core_cnt < CL) ? 256'h0 :
                       (sw32(core_header[31:0]) == hit_nonce) ? rev256(GEN_INT) : rev256(MISS_INT);

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic         found;
    logic [31:0]  nonce;
    logic [255:0] hash_int;
    int           trials;
    logic [31:0]  hdr_lo;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           accept_cyc = 0;
  int           rv_cyc = 0;
  int           trials = 0;
  logic [31:0]  nonces[$];
  logic [31:0]  last_hdr_lo = 32'h0;
  logic [607:0] exp_hdr_hi = '0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin : monitor
    logic prev_cr;
    logic prev_rv;
    logic prev_busy;
    exp_t e;
    prev_cr = 1'b1; prev_rv = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        accept_cyc = cyc;
        trials = 0;
        nonces.delete();
      end
      if (prev_cr && !core_reset && busy) begin
        trials++;
        nonces.push_back(cur_nonce);
        last_hdr_lo = core_header[31:0];
        chk("core_header_hi", {255'b0, core_header[639:32] == exp_hdr_hi}, 256'd1);
      end
      if (res_valid && !prev_rv) rv_cyc = cyc;
      prev_cr = core_reset;
      prev_rv = res_valid;
      prev_busy = busy;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {255'b0, res_valid}, 256'd0);
        end else begin
          e = sb.pop_front();
          chk("res_found", {255'b0, res_found}, {255'b0, e.found});
          chk("res_nonce", {224'b0, res_nonce}, {224'b0, e.nonce});
          chk("res_hash_int", rev256(res_hash), e.hash_int);
          chk("trials", 256'(trials), 256'(e.trials));
          chk("latency", 256'(rv_cyc - accept_cyc), 256'(e.trials * TRIAL));
          chk("last_hdr_lo", {224'b0, last_hdr_lo}, {224'b0, e.hdr_lo});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic expect_res(input logic f, input logic [31:0] n, input logic [255:0] h,
                            input int t, input logic [31:0] hl);
    exp_t e;
    e.found = f; e.nonce = n; e.hash_int = h; e.trials = t; e.hdr_lo = hl;
    sb.push_back(e);
  endtask

  task automatic start_job(input logic [639:0] hdr, input logic [31:0] s, input logic [31:0] en,
                           input logic [255:0] tgt, input logic [31:0] hn, input logic abort_too);
    @(negedge clk);
    hit_nonce = hn;
    exp_hdr_hi = hdr[639:32];
    job_header = hdr; job_nonce_start = s; job_nonce_end = en; job_target = tgt;
    job_valid = 1'b1;
    abort = abort_too;
    @(posedge clk); #1;
    job_valid = 1'b0;
    abort = 1'b0;
    // Scramble the job inputs; the running job must not see these.
    job_header = ~hdr; job_nonce_start = s + 32'd100; job_nonce_end = s; job_target = '1;
  endtask

  task automatic wait_res(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (i == limit) chk({name, "_timeout"}, 256'd0, 256'd1);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (job_ready) break;
    end
    if (i == limit) chk("idle_timeout", 256'd0, 256'd1);
  endtask

  task automatic wait_run(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy && !core_reset) break;
    end
    if (i == limit) chk("run_timeout", 256'd0, 256'd1);
  endtask

  task automatic chk_idle_ctrl(input string tag);
    chk({tag, "_job_ready"}, {255'b0, job_ready}, 256'd1);
    chk({tag, "_busy"}, {255'b0, busy}, 256'd0);
    chk({tag, "_core_reset"}, {255'b0, core_reset}, 256'd1);
    chk({tag, "_res_valid"}, {255'b0, res_valid}, 256'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle_ctrl(tag);
    chk({tag, "_res_found"}, {255'b0, res_found}, 256'd0);
    chk({tag, "_cur_nonce"}, {224'b0, cur_nonce}, 256'd0);
    chk({tag, "_res_nonce"}, {224'b0, res_nonce}, 256'd0);
    chk({tag, "_res_hash"}, res_hash, 256'd0);
    chk({tag, "_core_header"}, {255'b0, |core_header}, 256'd0);
  endtask

  initial begin : driver
    logic         s_found;
    logic [31:0]  s_nonce;
    logic [255:0] s_hash;
    reset_n = 1'b0; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b1;
    job_header = '0; job_nonce_start = '0; job_nonce_end = '0; job_target = '0;
    #23;
    chk_reset_vals("por");
    @(negedge clk); reset_n = 1'b1;

    // Genesis-style hit with 10 cycles of result backpressure.
    res_ready = 1'b0;
    expect_res(1'b1, 32'h7C2BAC1D, GEN_INT, 3, sw32(32'h7C2BAC1D));
    start_job(HDR_A, 32'h7C2BAC1B, 32'h7C2BAC1F, TGT_GEN, 32'h7C2BAC1D, 1'b0);
    wait_res(5 * TRIAL, "genesis");
    s_found = res_found; s_nonce = res_nonce; s_hash = res_hash;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_res_valid", {255'b0, res_valid}, 256'd1);
      chk("bp_job_ready", {255'b0, job_ready}, 256'd0);
      chk("bp_res_stable", {255'b0, (res_found === s_found) && (res_nonce === s_nonce) && (res_hash === s_hash)}, 256'd1);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_job_ready_after", {255'b0, job_ready}, 256'd1);
    chk("bp_res_valid_after", {255'b0, res_valid}, 256'd0);

    // Single-nonce range, miss; abort held during acceptance is ignored.
    expect_res(1'b0, 32'h7C2BAC1C, MISS_INT, 1, sw32(32'h7C2BAC1C));
    start_job(HDR_B, 32'h7C2BAC1C, 32'h7C2BAC1C, TGT_GEN, 32'h7C2BAC1D, 1'b1);
    wait_res(3 * TRIAL, "exhaust");
    wait_idle(10);

    // Wrap through 0xFFFFFFFF -> 0 with an unreachable target.
    expect_res(1'b0, 32'h00000001, MISS_INT, 4, 32'h01000000);
    start_job(HDR_A, 32'hFFFFFFFE, 32'h00000001, 256'h0, 32'h12345678, 1'b0);
    wait_res(6 * TRIAL, "wrap");
    wait_idle(10);
    chk("wrap_count", 256'(nonces.size()), 256'd4);
    if (nonces.size() == 4) begin
      chk("wrap_n0", {224'b0, nonces[0]}, {224'b0, 32'hFFFFFFFE});
      chk("wrap_n1", {224'b0, nonces[1]}, {224'b0, 32'hFFFFFFFF});
      chk("wrap_n2", {224'b0, nonces[2]}, 256'd0);
      chk("wrap_n3", {224'b0, nonces[3]}, 256'd1);
    end

    // Hash exactly equal to target is a hit.
    expect_res(1'b1, 32'd5, GEN_INT, 1, sw32(32'd5));
    start_job(HDR_B, 32'd5, 32'd5, GEN_INT, 32'd5, 1'b0);
    wait_res(3 * TRIAL, "equal");
    wait_idle(10);

    // One below the hash is a miss.
    expect_res(1'b0, 32'd5, GEN_INT, 1, sw32(32'd5));
    start_job(HDR_A, 32'd5, 32'd5, GEN_INT - 256'd1, 32'd5, 1'b0);
    wait_res(3 * TRIAL, "below");
    wait_idle(10);

    // Hit on the last nonce of the range.
    expect_res(1'b1, 32'd10, GEN_INT, 2, sw32(32'd10));
    start_job(HDR_B, 32'd9, 32'd10, TGT_GEN, 32'd10, 1'b0);
    wait_res(4 * TRIAL, "last_hit");
    wait_idle(10);

    // Abort during RUN.
    start_job(HDR_A, 32'd0, 32'd10, TGT_GEN, 32'd3, 1'b0);
    wait_run(20);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_idle_ctrl("abort_run");
    repeat (TRIAL) @(negedge clk);
    chk("abort_run_quiet", {255'b0, res_valid}, 256'd0);

    // Abort during REPORT (result withheld).
    res_ready = 1'b0;
    start_job(HDR_B, 32'h7C2BAC1D, 32'h7C2BAC1D, TGT_GEN, 32'h7C2BAC1D, 1'b0);
    wait_res(3 * TRIAL, "abort_rep");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_idle_ctrl("abort_rep");
    res_ready = 1'b1;

    // Next job after aborts runs normally.
    expect_res(1'b1, 32'h7C2BAC1D, GEN_INT, 2, sw32(32'h7C2BAC1D));
    start_job(HDR_A, 32'h7C2BAC1C, 32'h7C2BAC1E, TGT_GEN, 32'h7C2BAC1D, 1'b0);
    wait_res(4 * TRIAL, "post_abort");
    wait_idle(10);

    // Asynchronous reset mid-RUN, away from any clock edge.
    start_job(HDR_B, 32'd0, 32'd10, TGT_GEN, 32'd3, 1'b0);
    wait_run(20);
    repeat (10) @(negedge clk);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk); reset_n = 1'b1;
    repeat (TRIAL) @(negedge clk);
    chk("async_rst_quiet", {255'b0, res_valid}, 256'd0);

    // Recovery job.
    expect_res(1'b0, 32'h7C2BAC1C, MISS_INT, 1, sw32(32'h7C2BAC1C));
    start_job(HDR_A, 32'h7C2BAC1C, 32'h7C2BAC1C, TGT_GEN, 32'h7C2BAC1D, 1'b0);
    wait_res(3 * TRIAL, "recover");
    wait_idle(10);

    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_sweeper.md
# sha256_nonce_sweeper

Job-level controller for the double-SHA-256 core. It accepts one mining job (80-byte header, inclusive nonce range, 256-bit target), inserts each nonce into the header and runs the core once per nonce. Each digest is compared against the target, and the first hit or range exhaustion is reported on a valid/ready result port. It sits between the job source and a single `sha256_doublehash_core` instance, which it sequences through that core's active-high synchronous `reset`.

## Interface
- `CORE_LATENCY`, 200: cycles from `core_reset` deassertion until `core_digest` is stable; must be ≥ the core's worst-case latency.
- `RESET_CYCLES`, 2: cycles `core_reset` is held high before each trial; ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job offered.
- `job_ready` out 1: high only in IDLE.
- `job_header` in 640: header; bits [31:0] (nonce field) ignored.
- `job_nonce_start` in 32: first nonce.
- `job_nonce_end` in 32: last nonce, inclusive.
- `job_target` in 256: hash integer must be ≤ this.
- `abort` in 1: cancel job, no result.
- `core_reset` out 1: drives core `reset`.
- `core_header` out 640: drives core `blockHeader`.
- `core_digest` in 256: core `digest`.
- `res_valid` out 1: result pending.
- `res_ready` in 1: result consumed.
- `res_found` out 1: 1 = hit, 0 = range exhausted.
- `res_nonce` out 32: hit nonce, or last nonce tried.
- `res_hash` out 256: raw `core_digest` for `res_nonce`.
- `busy` out 1: not IDLE.
- `cur_nonce` out 32: nonce under trial.

## Operation
- States: IDLE, LOAD, CORE_RST, RUN, CHECK, REPORT.
- IDLE: `core_reset`=1. Accept on `job_valid && job_ready`; latch header, end and target; `cur_nonce`←start → LOAD.
- LOAD: `core_header` ← {header[639:32], bswap32(`cur_nonce`)} → CORE_RST.
- CORE_RST: `core_reset`=1 for `RESET_CYCLES` cycles → RUN.
- RUN: `core_reset`=0; count `CORE_LATENCY` cycles → CHECK.
- CHECK: hash integer = byte-reversed `core_digest`. Hit = hash ≤ target.
  - Hit → REPORT, found=1.
  - Otherwise, `cur_nonce`==end → REPORT, found=0.
  - Otherwise `cur_nonce`+1 (mod 2^32) → LOAD.
- REPORT: `res_*` registered on CHECK exit; `res_valid`=1 and held stable until `res_ready` → IDLE.
- Range wraps: start > end sweeps through 0xFFFFFFFF → 0. start == end is one trial. Full 2^32 range: end = start−1.
- Hit on the last nonce reports found=1.
- `abort` in any non-IDLE state (including REPORT) → IDLE next cycle; `res_valid` drops; no result. `abort` is ignored in IDLE.
- `abort` with `res_ready` in REPORT → IDLE, same outcome either way.
- Job inputs are sampled only at acceptance; later changes have no effect.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `job_ready`=1, `core_reset`=1, `busy`=0, `res_valid`=0, `res_found`=0.
  - `cur_nonce`=0, `res_nonce`=0, `res_hash`=0, `core_header`=0.
- `reset_n` low mid-job discards the job at once; `core_reset` asserts at once.
- All outputs are registered except `job_ready` (= state==IDLE) and `busy`.
- Per trial: 1 (LOAD) + `RESET_CYCLES` + `CORE_LATENCY` + 1 (CHECK) cycles; 204 at defaults.
- Acceptance to first LOAD: 1 cycle. CHECK to `res_valid`: 1 cycle. Handshake to `job_ready`: 1 cycle.

## Structure
- `sha256_miner_pkg`:
  - state enum.
  - `HEADER_W`=640, `DIGEST_W`=256, `NONCE_W`=32.
  - functions `bswap32` and `bswap256`.
- Sub-module `sha256_target_cmp`: combinational byte-reverse plus ≤ compare, reused by future multi-core schedulers.
- Core instantiated by the parent, not inside this block.

## Test plan
- Genesis hit: genesis header, start 0x7C2BAC1B, end 0x7C2BAC1F, target 0x00000000FFFF0000…0 → exactly 3 trials; res_found=1; res_nonce=0x7C2BAC1D; byte-reversed res_hash = 0x000000000019d668…e26f.
- Exhaustion: start=end=0x7C2BAC1C, same target → 1 trial; res_found=0; res_nonce=0x7C2BAC1C.
- Wrap: start 0xFFFFFFFE, end 0x00000001, target 0 → `cur_nonce` runs FFFFFFFE, FFFFFFFF, 0, 1; res_found=0; res_nonce=1; `core_header[31:0]`=0x01000000 on the last trial.
- Backpressure: hold `res_ready` low 10 cycles in REPORT → `res_*` stable and `job_ready`=0; `job_ready`=1 the cycle after the handshake.
- Abort in RUN and abort in REPORT → IDLE next cycle; `res_valid`=0; `core_reset`=1; next job runs normally.
- `reset_n` pulsed low mid-RUN, asynchronous to `clk` → all outputs at reset values before the next edge; no result emitted.
